// File: rtl/tube_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tube_pkg
// Description : Shared types, default constants and tube-pattern helpers for
//               the scrolling playfield and its collision checker.
// Revision    : 1.0 - initial release
// ============================================================================
package tube_pkg;

  localparam int C_ROWS      = 16;
  localparam int C_COLS      = 16;
  localparam int C_TUBE_W    = 2;
  localparam int C_GAP       = 4;
  localparam int C_MIN_SPACE = 4;
  localparam int C_BIRD_COL  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    SPACE = 2'd2
  } state_t;

  // One row of a tube column: solid (1) everywhere except inside the gap.
  function automatic logic tube_bit(input int row, input int gap, input int gap_lo);
    return !((row >= gap_lo) && (row < gap_lo + gap));
  endfunction

  // Full tube column for the default matrix height and gap size.
  function automatic logic [C_ROWS-1:0] tube_col(input int gap_lo);
    logic [C_ROWS-1:0] v;
    v = '0;
    for (int r = 0; r < C_ROWS; r++) begin
      v[r] = tube_bit(r, C_GAP, gap_lo);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tube_col_gen.sv
`default_nettype none
// ============================================================================
// Module      : tube_col_gen
// Description : Clamps a requested gap position so the gap never runs off the
//               top of the matrix, then builds the matching tube column.
// Revision    : 1.0 - initial release
// ============================================================================
module tube_col_gen
  import tube_pkg::*;
#(
  parameter int ROWS = C_ROWS,
  parameter int GAP  = C_GAP
) (
  input  logic [$clog2(ROWS)-1:0] i_gap_pos,
  output logic [$clog2(ROWS)-1:0] o_gap_lo,
  output logic [ROWS-1:0]         o_col
);

  localparam int GW = $clog2(ROWS);
  localparam logic [GW-1:0] C_GAP_MAX = GW'(ROWS - GAP);

  logic [GW-1:0] w_gap_lo;

  // Saturate the gap position (no wrap-around) and expand it into a column.
  always_comb begin
    w_gap_lo = (i_gap_pos > C_GAP_MAX) ? C_GAP_MAX : i_gap_pos;
    o_col    = '0;
    for (int r = 0; r < ROWS; r++) begin
      o_col[r] = tube_bit(r, GAP, int'(w_gap_lo));
    end
  end

  assign o_gap_lo = w_gap_lo;

endmodule
`default_nettype wire

// File: rtl/tube_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tube_scroller
// Description : Scrolling Flappy-Bird playfield. Shifts COLS columns left on
//               each tick, injects tubes at the right edge from its own
//               IDLE/EMIT/SPACE sequencer, freezes on death and pulses score
//               when a tube's trailing column leaves the bird column.
// Revision    : 1.0 - initial release
// ============================================================================
module tube_scroller
  import tube_pkg::*;
#(
  parameter int ROWS      = C_ROWS,
  parameter int COLS      = C_COLS,
  parameter int TUBE_W    = C_TUBE_W,
  parameter int GAP       = C_GAP,
  parameter int MIN_SPACE = C_MIN_SPACE,
  parameter int BIRD_COL  = C_BIRD_COL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_tick,
  input  logic                    i_dead,
  input  logic                    i_clear,
  input  logic                    i_spawn_req,
  input  logic [$clog2(ROWS)-1:0] i_gap_pos,
  output logic                    o_spawn_ack,
  output logic                    o_busy,
  output logic                    o_score_pulse,
  output logic [COLS*ROWS-1:0]    o_field
);

  localparam int GW  = $clog2(ROWS);
  localparam int WCW = (TUBE_W > 1) ? $clog2(TUBE_W) : 1;
  localparam int SCW = $clog2(MIN_SPACE + 1);

  state_t                r_state;
  logic [GW-1:0]         r_gap_lo;
  logic [WCW-1:0]        r_wcnt;
  logic [SCW-1:0]        r_scnt;
  logic                  r_ack;
  logic                  r_busy;
  logic                  r_score;
  logic [COLS*ROWS-1:0]  r_field;

  logic [GW-1:0]         w_gen_in;
  logic [GW-1:0]         w_gap_lo_new;
  logic [ROWS-1:0]       w_tube_col;
  logic [ROWS-1:0]       w_inject;
  logic [ROWS-1:0]       w_bird_col;
  logic [ROWS-1:0]       w_next_col;
  logic                  w_run;

  // A single generator serves both jobs: in IDLE it clamps the incoming
  // request, otherwise it renders the latched (already clamped) gap.
  assign w_gen_in = (r_state == IDLE) ? i_gap_pos : r_gap_lo;

  tube_col_gen #(
    .ROWS (ROWS),
    .GAP  (GAP)
  ) u_col_gen (
    .i_gap_pos (w_gen_in),
    .o_gap_lo  (w_gap_lo_new),
    .o_col     (w_tube_col)
  );

  assign w_run      = !i_clear && !i_dead;
  assign w_inject   = (r_state == EMIT) ? w_tube_col : '0;
  assign w_bird_col = r_field[BIRD_COL*ROWS +: ROWS];
  assign w_next_col = r_field[(BIRD_COL+1)*ROWS +: ROWS];

  // Tube sequencer: accept a request, emit TUBE_W columns, then MIN_SPACE blanks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gap_lo <= '0;
      r_wcnt   <= '0;
      r_scnt   <= '0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
    end else if (i_clear) begin
      r_state  <= IDLE;
      r_gap_lo <= '0;
      r_wcnt   <= '0;
      r_scnt   <= '0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
    end else if (i_dead) begin
      r_ack    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_spawn_req) begin
            r_gap_lo <= w_gap_lo_new;
            r_wcnt   <= '0;
            r_ack    <= 1'b1;
            r_state  <= EMIT;
            r_busy   <= 1'b1;
          end
        end
        EMIT: begin
          if (i_tick) begin
            if (r_wcnt == WCW'(TUBE_W - 1)) begin
              r_state <= SPACE;
              r_scnt  <= SCW'(MIN_SPACE);
              r_wcnt  <= '0;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        SPACE: begin
          if (i_tick) begin
            r_scnt <= r_scnt - 1'b1;
            if (r_scnt == SCW'(1)) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Playfield shift register plus score detection on the outgoing bird column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_field <= '0;
      r_score <= 1'b0;
    end else if (i_clear) begin
      r_field <= '0;
      r_score <= 1'b0;
    end else if (!w_run) begin
      r_score <= 1'b0;
    end else begin
      r_score <= 1'b0;
      if (i_tick) begin
        r_field <= {w_inject, r_field[COLS*ROWS-1:ROWS]};
        r_score <= (|w_bird_col) && !(|w_next_col);
      end
    end
  end

  assign o_spawn_ack   = r_ack;
  assign o_busy        = r_busy;
  assign o_score_pulse = r_score;
  assign o_field       = r_field;

endmodule
`default_nettype wire

// File: tb/tb_tube_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_tube_scroller
// Description : Directed self-checking bench for tube_scroller at default
//               parameters (16x16 field, 2-wide tubes, 4-row gap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tube_scroller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick;
  logic         dead;
  logic         clear;
  logic         spawn_req;
  logic [3:0]   gap_pos;
  logic         ack;
  logic         busy;
  logic         score;
  logic [255:0] field;

  int checks   = 0;
  int failures = 0;
  int npulse   = 0;

  always #5 clk = ~clk;

  tube_scroller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_tick        (tick),
    .i_dead        (dead),
    .i_clear       (clear),
    .i_spawn_req   (spawn_req),
    .i_gap_pos     (gap_pos),
    .o_spawn_ack   (ack),
    .o_busy        (busy),
    .o_score_pulse (score),
    .o_field       (field)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; dead = 1'b0; clear = 1'b0;
    spawn_req = 1'b0; gap_pos = 4'd0;

    // Reset state
    repeat (3) step();
    check("rst_field", field, 256'h0);
    check("rst_busy",  busy,  1'b0);
    check("rst_ack",   ack,   1'b0);
    check("rst_score", score, 1'b0);
    #3 rst_n = 1'b1;
    step();

    // First tube, gap_pos=5 -> column FE1F; request stays held
    spawn_req = 1'b1; gap_pos = 4'd5;
    step();
    check("acc_a_ack",  ack,  1'b1);
    check("acc_a_busy", busy, 1'b1);
    step();
    check("acc_a_ack_drop", ack, 1'b0);
    check("no_tick_field",  field, 256'h0);
    tick_once();
    check("a_tick1", field, {16'hFE1F, 240'h0});
    tick_once();
    check("a_tick2", field, {16'hFE1F, 16'hFE1F, 224'h0});
    check("a_tick2_busy", busy, 1'b1);
    tick_once();
    check("a_tick3", field, {16'h0, 16'hFE1F, 16'hFE1F, 208'h0});
    check("a_tick3_ack", ack, 1'b0);
    tick_once();
    check("space_ack4", ack, 1'b0);
    tick_once();
    check("space_ack5", ack, 1'b0);
    check("space_busy5", busy, 1'b1);
    tick_once();
    check("space_ack6", ack, 1'b0);
    check("idle_busy6", busy, 1'b0);
    check("a_tick6", field, {64'h0, 16'hFE1F, 16'hFE1F, 160'h0});

    // Second tube, gap_pos=14 clamps to 12 -> 0FFF
    gap_pos = 4'd14;
    step();
    check("acc_b_ack", ack, 1'b1);
    spawn_req = 1'b0;
    tick_once();
    tick_once();
    check("b_tick8", field, {16'h0FFF, 16'h0FFF, 64'h0, 16'hFE1F, 16'hFE1F, 128'h0});
    repeat (4) tick_once();
    check("b_tick12", field, {64'h0, 16'h0FFF, 16'h0FFF, 64'h0, 16'hFE1F, 16'hFE1F, 64'h0});
    check("b_idle_busy", busy, 1'b0);

    // Third tube, gap_pos=0 -> FFF0
    spawn_req = 1'b1; gap_pos = 4'd0;
    step();
    check("acc_c_ack", ack, 1'b1);
    spawn_req = 1'b0;
    tick_once();
    check("c_tick13", field,
          {16'hFFF0, 64'h0, 16'h0FFF, 16'h0FFF, 64'h0, 16'hFE1F, 16'hFE1F, 48'h0});

    // Asynchronous reset in the middle of EMIT
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_field", field, 256'h0);
    check("async_rst_busy",  busy,  1'b0);
    check("async_rst_ack",   ack,   1'b0);
    #3 rst_n = 1'b1;
    step();
    step();
    check("post_rst_field", field, 256'h0);
    check("post_rst_busy",  busy,  1'b0);

    // Freeze on death
    spawn_req = 1'b1; gap_pos = 4'd5;
    step();
    check("acc_d_ack", ack, 1'b1);
    spawn_req = 1'b0;
    tick_once();
    check("d_tick1", field, {16'hFE1F, 240'h0});
    dead = 1'b1; tick = 1'b1; spawn_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("dead_field%0d", i), field, {16'hFE1F, 240'h0});
      check($sformatf("dead_busy%0d", i),  busy,  1'b1);
      check($sformatf("dead_ack%0d", i),   ack,   1'b0);
    end
    dead = 1'b0; spawn_req = 1'b0;
    step();
    tick = 1'b0;
    check("thaw_field", field, {16'hFE1F, 16'hFE1F, 224'h0});
    check("thaw_busy",  busy,  1'b1);
    dead = 1'b1; clear = 1'b1;
    step();
    check("clear_field", field, 256'h0);
    check("clear_busy",  busy,  1'b0);
    check("clear_ack",   ack,   1'b0);
    clear = 1'b0; dead = 1'b0;
    tick_once();
    check("clear_idle_field", field, 256'h0);
    check("clear_idle_busy",  busy,  1'b0);

    // Score: single tube, tick every cycle, pulse only after tick 15
    spawn_req = 1'b1; gap_pos = 4'd5;
    step();
    check("acc_e_ack", ack, 1'b1);
    spawn_req = 1'b0;
    tick = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (score === 1'b1) npulse++;
      check($sformatf("score_k%0d", k), score, (k == 15));
    end
    tick = 1'b0;
    check("score_count", npulse, 1);
    check("score_field_empty", field, 256'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
